// File: rtl/trace_buffer.sv
// Trace record buffer: captures completed-instruction records into a circular FIFO
// and streams each one out as WORD_WIDTH beats, LSB word first, counting dropped records.

module trace_buffer_checker #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LW         = 5
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  flush,
    input logic                  out_valid,
    input logic                  out_ready,
    input logic [WORD_WIDTH-1:0] out_data,
    input logic                  out_last,
    input logic [LW-1:0]         level,
    input logic                  full
);

    // A stalled beat must stay put until the sink takes it.
    stall_hold_a: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data) && $stable(out_last)));

    level_bound_a: assert property (@(posedge clk) disable iff (rst)
        (level <= LW'(DEPTH)) && (full == (level == LW'(DEPTH))));

endmodule

module trace_buffer #(
    parameter int REC_WIDTH  = 128,
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_data_ready,
    input  logic [REC_WIDTH-1:0]     trace_data_i,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_WIDTH-1:0]     drop_count
);

    localparam int NWORDS = REC_WIDTH / WORD_WIDTH;
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = AW + 1;
    localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [WIDX_W-1:0]    LAST_WIDX = WIDX_W'(NWORDS - 1);
    localparam logic [WIDX_W-1:0]    WIDX_ZERO = WIDX_W'(0);
    localparam logic [PW-1:0]        PTR_ZERO  = PW'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [REC_WIDTH-1:0]  mem_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         level_r;
    logic                  full_r;
    state_t                state_r;
    logic [WIDX_W-1:0]     widx_r;
    logic                  out_valid_r;
    logic                  out_last_r;
    logic [WORD_WIDTH-1:0] out_data_r;
    logic                  overflow_r;
    logic [CNT_WIDTH-1:0]  drop_count_r;

    logic                  pop_done_s;
    logic                  push_s;
    logic                  drop_s;
    logic [PW-1:0]         wr_ptr_s;
    logic [PW-1:0]         rd_ptr_s;
    logic [PW-1:0]         level_s;
    logic                  full_s;
    state_t                state_s;
    logic [WIDX_W-1:0]     widx_s;
    logic [REC_WIDTH-1:0]  head_s;
    logic [WORD_WIDTH-1:0] word_s;

    // Push/pop/drop decisions and the pointer values they produce.
    always_comb begin
        pop_done_s = out_valid_r && out_ready && out_last_r;
        push_s     = trace_data_ready && (!full_r || pop_done_s);
        drop_s     = trace_data_ready && full_r && !pop_done_s;
        if (push_s) begin
            wr_ptr_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_done_s) begin
            rd_ptr_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        level_s = wr_ptr_s - rd_ptr_s;
        full_s  = (wr_ptr_s[AW] != rd_ptr_s[AW]) && (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);
    end

    // Next head record; a record written this very edge into the next head slot is forwarded.
    always_comb begin
        if (push_s && (wr_ptr_r == rd_ptr_s)) begin
            head_s = trace_data_i;
        end else begin
            head_s = mem_r[rd_ptr_s[AW-1:0]];
        end
        word_s = head_s[int'(widx_s) * WORD_WIDTH +: WORD_WIDTH];
    end

    // Stream FSM next-state and word index.
    always_comb begin
        state_s = state_r;
        widx_s  = widx_r;
        case (state_r)
            IDLE: begin
                if (level_r != PTR_ZERO) begin
                    state_s = SEND;
                    widx_s  = WIDX_ZERO;
                end else begin
                    state_s = IDLE;
                    widx_s  = WIDX_ZERO;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (widx_r == LAST_WIDX) begin
                        widx_s = WIDX_ZERO;
                        if (level_s != PTR_ZERO) begin
                            state_s = SEND;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        widx_s  = widx_r + WIDX_W'(1);
                        state_s = SEND;
                    end
                end else begin
                    widx_s  = widx_r;
                    state_s = SEND;
                end
            end
            default: begin
                state_s = IDLE;
                widx_s  = WIDX_ZERO;
            end
        endcase
    end

    // Record storage; flush and reset discard the push of that cycle.
    always_ff @(posedge clk) begin
        if (push_s && !rst && !flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= trace_data_i;
        end
    end

    // Pointers, FSM state, registered stream outputs and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            level_r      <= PTR_ZERO;
            full_r       <= 1'b0;
            state_r      <= IDLE;
            widx_r       <= WIDX_ZERO;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_data_r   <= {WORD_WIDTH{1'b0}};
            overflow_r   <= 1'b0;
            drop_count_r <= {CNT_WIDTH{1'b0}};
        end else if (flush) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            level_r      <= PTR_ZERO;
            full_r       <= 1'b0;
            state_r      <= IDLE;
            widx_r       <= WIDX_ZERO;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_data_r   <= {WORD_WIDTH{1'b0}};
        end else begin
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            level_r     <= level_s;
            full_r      <= full_s;
            state_r     <= state_s;
            widx_r      <= widx_s;
            out_valid_r <= (state_s == SEND);
            out_last_r  <= (state_s == SEND) && (widx_s == LAST_WIDX);
            if (state_s == SEND) begin
                out_data_r <= word_s;
            end else begin
                out_data_r <= {WORD_WIDTH{1'b0}};
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != CNT_MAX) begin
                    drop_count_r <= drop_count_r + CNT_WIDTH'(1);
                end else begin
                    drop_count_r <= drop_count_r;
                end
            end else begin
                overflow_r   <= overflow_r;
                drop_count_r <= drop_count_r;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign out_data   = out_data_r;
    assign level      = level_r;
    assign full       = full_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

    trace_buffer_checker #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .LW         (PW)
    ) u_checker (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .out_valid  (out_valid_r),
        .out_ready  (out_ready),
        .out_data   (out_data_r),
        .out_last   (out_last_r),
        .level      (level_r),
        .full       (full_r)
    );

endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer: default instance plus a narrow DEPTH=2/CNT_WIDTH=4
// instance for counter saturation and single-word records.

module tb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int NW    = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         trace_data_ready;
    logic [127:0] trace_data_i;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [4:0]   level;
    logic         full;
    logic         overflow;
    logic [15:0]  drop_count;

    logic         s_valid;
    logic [31:0]  s_data;
    logic         s_flush;
    logic         s_out_valid;
    logic         s_ready;
    logic [31:0]  s_out_data;
    logic         s_out_last;
    logic [1:0]   s_level;
    logic         s_full;
    logic         s_overflow;
    logic [3:0]   s_drop;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];
    int mdl_level = 0;
    int mdl_drops = 0;

    always #5 clk = ~clk;

    trace_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .trace_data_ready (trace_data_ready),
        .trace_data_i     (trace_data_i),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .level            (level),
        .full             (full),
        .overflow         (overflow),
        .drop_count       (drop_count)
    );

    trace_buffer #(
        .REC_WIDTH  (32),
        .WORD_WIDTH (32),
        .DEPTH      (2),
        .CNT_WIDTH  (4)
    ) dut_small (
        .clk              (clk),
        .rst              (rst),
        .trace_data_ready (s_valid),
        .trace_data_i     (s_data),
        .flush            (s_flush),
        .out_valid        (s_out_valid),
        .out_ready        (s_ready),
        .out_data         (s_out_data),
        .out_last         (s_out_last),
        .level            (s_level),
        .full             (s_full),
        .overflow         (s_overflow),
        .drop_count       (s_drop)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_rec(input int id);
        logic [127:0] r;
        for (int k = 0; k < NW; k++) begin
            r[k*32 +: 32] = 32'hA000_0000 | (32'(id) << 8) | 32'(k);
        end
        return r;
    endfunction

    // One clock: score the beat/push seen at negedge, then land just after the posedge.
    task automatic tick();
        logic [32:0] e;
        bit pop;
        bit was_full;
        @(negedge clk);
        pop = 1'b0;
        if (rst) begin
            exp_q.delete();
            mdl_level = 0;
            mdl_drops = 0;
        end else if (flush) begin
            exp_q.delete();
            mdl_level = 0;
        end else begin
            was_full = (mdl_level == DEPTH);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("beat_expected", 128'(exp_q.size() != 0), 128'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat_data", 128'(out_data), 128'(e[31:0]));
                    check_eq("beat_last", 128'(out_last), 128'(e[32]));
                    if (e[32]) begin
                        pop = 1'b1;
                        mdl_level--;
                    end
                end
            end
            if (trace_data_ready) begin
                if (!was_full || pop) begin
                    for (int k = 0; k < NW; k++) begin
                        exp_q.push_back({(k == NW - 1), trace_data_i[k*32 +: 32]});
                    end
                    mdl_level++;
                end else if (mdl_drops < 65535) begin
                    mdl_drops++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic [127:0] rec);
        trace_data_i     = rec;
        trace_data_ready = 1'b1;
        tick();
        trace_data_ready = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        out_ready = 1'b1;
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
            tick();
        end
        check_eq({tag, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
        check_eq({tag, "_level"}, 128'(level), 128'd0);
        check_eq({tag, "_valid_off"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        logic [127:0] rec1;
        rst = 1'b1; flush = 1'b0; trace_data_ready = 1'b0; trace_data_i = 128'd0; out_ready = 1'b0;
        s_valid = 1'b0; s_data = 32'd0; s_flush = 1'b0; s_ready = 1'b0;
        #1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_valid", 128'(out_valid), 128'd0);
        check_eq("rst_last", 128'(out_last), 128'd0);
        check_eq("rst_data", 128'(out_data), 128'd0);
        check_eq("rst_level", 128'(level), 128'd0);
        check_eq("rst_full", 128'(full), 128'd0);
        check_eq("rst_overflow", 128'(overflow), 128'd0);
        check_eq("rst_drops", 128'(drop_count), 128'd0);
        check_eq("rst_s_drops", 128'(s_drop), 128'd0);

        // Single record: latency and four consecutive beats
        rec1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        out_ready = 1'b1;
        push_rec(rec1);
        check_eq("lat_n_valid", 128'(out_valid), 128'd0);
        check_eq("lat_n_level", 128'(level), 128'd1);
        tick();
        check_eq("lat_n1_valid", 128'(out_valid), 128'd1);
        check_eq("lat_n1_word0", 128'(out_data), 128'h1111_1111);
        for (int i = 0; i < NW; i++) begin
            tick();
        end
        check_eq("t1_consecutive", 128'(exp_q.size()), 128'd0);
        check_eq("t1_idle", 128'(out_valid), 128'd0);

        // Backpressure mid-record
        push_rec(mk_rec(100));
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", 128'(out_valid), 128'd1);
            check_eq("bp_data", 128'(out_data), 128'(exp_q[0][31:0]));
            check_eq("bp_last", 128'(out_last), 128'(exp_q[0][32]));
        end
        drain("t2", 40);

        // Overfill: 18 pushes into 16 slots
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            push_rec(mk_rec(i));
        end
        check_eq("t3_full", 128'(full), 128'd1);
        check_eq("t3_level", 128'(level), 128'd16);
        check_eq("t3_drops", 128'(drop_count), 128'd2);
        check_eq("t3_drops_model", 128'(drop_count), 128'(mdl_drops));
        check_eq("t3_overflow", 128'(overflow), 128'd1);
        drain("t3", 200);

        // Full with last beat and push in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_rec(mk_rec(200 + i));
        end
        check_eq("t4_full", 128'(full), 128'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8 && !(out_valid && out_last); i++) begin
            tick();
        end
        check_eq("t4_at_last", 128'(out_valid && out_last), 128'd1);
        push_rec(mk_rec(300));
        check_eq("t4_level", 128'(level), 128'd16);
        check_eq("t4_full_kept", 128'(full), 128'd1);
        check_eq("t4_drops", 128'(drop_count), 128'd2);
        drain("t4", 200);

        // Flush with records queued mid-send
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_rec(mk_rec(400 + i));
        end
        out_ready = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        trace_data_i = mk_rec(499);
        trace_data_ready = 1'b1;
        tick();
        flush = 1'b0;
        trace_data_ready = 1'b0;
        check_eq("t5_valid", 128'(out_valid), 128'd0);
        check_eq("t5_level", 128'(level), 128'd0);
        check_eq("t5_full", 128'(full), 128'd0);
        check_eq("t5_drops", 128'(drop_count), 128'd2);
        check_eq("t5_overflow", 128'(overflow), 128'd1);
        tick();
        tick();
        check_eq("t5_still_idle", 128'(out_valid), 128'd0);
        push_rec(mk_rec(500));
        drain("t5", 40);

        // Saturating counter and single-word records on the narrow instance
        for (int i = 0; i < 22; i++) begin
            s_data  = 32'hB000_0000 + 32'(i);
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        check_eq("t6_drops_sat", 128'(s_drop), 128'd15);
        check_eq("t6_overflow", 128'(s_overflow), 128'd1);
        check_eq("t6_level", 128'(s_level), 128'd2);
        check_eq("t6_full", 128'(s_full), 128'd1);
        s_ready = 1'b1;
        check_eq("t6_rec0_data", 128'(s_out_data), 128'hB000_0000);
        check_eq("t6_rec0_last", 128'(s_out_last), 128'd1);
        tick();
        check_eq("t6_rec1_data", 128'(s_out_data), 128'hB000_0001);
        check_eq("t6_rec1_last", 128'(s_out_last), 128'd1);
        tick();
        check_eq("t6_idle", 128'(s_out_valid), 128'd0);
        check_eq("t6_level_zero", 128'(s_level), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
